// File: rtl/rca_lsq_arbiter.sv
// Multi-row load/store queue for the RCA: round-robin row arbitration, in-order
// request FIFO toward the single LSU port, and a row-tag FIFO that routes load results back.
module rca_lsq_arbiter #(
    parameter int NUM_ROWS  = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_LOADS = 4,
    parameter int ROW_W     = $clog2(NUM_ROWS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ROWS-1:0]           req_valid,
    output logic [NUM_ROWS-1:0]           req_ready,
    input  logic [NUM_ROWS-1:0][31:0]     req_addr,
    input  logic [NUM_ROWS-1:0][31:0]     req_data,
    input  logic [NUM_ROWS-1:0][2:0]      req_fn3,
    input  logic [NUM_ROWS-1:0]           req_load,
    input  logic [NUM_ROWS-1:0]           req_store,
    output logic [31:0]                   lsu_rs1,
    output logic [31:0]                   lsu_rs2,
    output logic [2:0]                    lsu_fn3,
    output logic                          lsu_load,
    output logic                          lsu_store,
    output logic                          lsu_new_request,
    input  logic                          lsu_ready,
    output logic                          rca_lsu_lock,
    input  logic                          lsu_load_done,
    input  logic [31:0]                   lsu_load_data,
    output logic                          rsp_valid,
    output logic [ROW_W-1:0]              rsp_row,
    output logic [31:0]                   rsp_data,
    output logic                          fifo_full,
    output logic                          idle,
    output logic                          rsp_error
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
    localparam int OW = $clog2(MAX_LOADS + 1);

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [2:0]       fn3;
        logic             load;
        logic             store;
    } entry_t;

    entry_t           fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [ROW_W-1:0] tag_mem [MAX_LOADS];
    logic [TW-1:0]    tag_wr;
    logic [TW-1:0]    tag_rd;
    logic [OW-1:0]    outstanding;

    logic [ROW_W-1:0] rr_ptr;
    logic [ROW_W-1:0] winner;
    logic [ROW_W-1:0] scan_row;
    int               scan_idx;
    logic             found;
    logic             accept;
    logic             fifo_empty;
    logic             issue;
    logic             tag_push;
    logic             done_ok;
    entry_t           head;
    entry_t           new_entry;

    // Round-robin scan starting at rr_ptr; first requesting row wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        scan_row = '0;
        for (int k = 0; k < NUM_ROWS; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_ROWS) scan_idx = scan_idx - NUM_ROWS;
            scan_row = ROW_W'(scan_idx);
            if (!found && req_valid[scan_row]) begin
                found  = 1'b1;
                winner = scan_row;
            end
        end
    end

    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign accept     = found && !fifo_full;
    assign req_ready  = accept ? (NUM_ROWS'(1) << winner) : '0;

    assign new_entry = '{row:   winner,
                         addr:  req_addr[winner],
                         data:  req_data[winner],
                         fn3:   req_fn3[winner],
                         load:  req_load[winner],
                         store: req_store[winner]};

    assign head = fifo_empty ? '0 : fifo_mem[rd_ptr];

    // Stores bypass the load cap; loads need a free tag slot.
    assign issue    = !fifo_empty && lsu_ready && (head.store || (outstanding < OW'(MAX_LOADS)));
    assign tag_push = issue && head.load;
    assign done_ok  = lsu_load_done && (outstanding != '0);

    assign lsu_rs1         = head.addr;
    assign lsu_rs2         = head.data;
    assign lsu_fn3         = head.fn3;
    assign lsu_load        = head.load;
    assign lsu_store       = head.store;
    assign lsu_new_request = issue;

    assign idle         = fifo_empty && (outstanding == '0);
    assign rca_lsu_lock = !idle;

    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= new_entry;
        if (tag_push) tag_mem[tag_wr] <= head.row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                rr_ptr <= (winner == ROW_W'(NUM_ROWS - 1)) ? '0 : winner + ROW_W'(1);
            end
            if (issue) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (accept && !issue) count <= count + CW'(1);
            else if (!accept && issue) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
        end else begin
            if (tag_push) tag_wr <= (tag_wr == TW'(MAX_LOADS - 1)) ? '0 : tag_wr + TW'(1);
            if (done_ok) tag_rd <= (tag_rd == TW'(MAX_LOADS - 1)) ? '0 : tag_rd + TW'(1);
            if (tag_push && !done_ok) outstanding <= outstanding + OW'(1);
            else if (!tag_push && done_ok) outstanding <= outstanding - OW'(1);
        end
    end

    // Returns arrive in issue order, so the oldest tag names the requesting row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_row   <= '0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= done_ok;
            if (done_ok) begin
                rsp_row  <= tag_mem[tag_rd];
                rsp_data <= lsu_load_data;
            end
            if (lsu_load_done && (outstanding == '0)) rsp_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rca_lsq_arbiter.sv
// Bench for rca_lsq_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_rca_lsq_arbiter;

    localparam int NR = 4;
    localparam int D  = 4;
    localparam int ML = 4;
    localparam int RW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0][31:0]  req_addr;
    logic [NR-1:0][31:0]  req_data;
    logic [NR-1:0][2:0]   req_fn3;
    logic [NR-1:0]        req_load;
    logic [NR-1:0]        req_store;
    logic [31:0]          lsu_rs1;
    logic [31:0]          lsu_rs2;
    logic [2:0]           lsu_fn3;
    logic                 lsu_load;
    logic                 lsu_store;
    logic                 lsu_new_request;
    logic                 lsu_ready;
    logic                 rca_lsu_lock;
    logic                 lsu_load_done;
    logic [31:0]          lsu_load_data;
    logic                 rsp_valid;
    logic [RW-1:0]        rsp_row;
    logic [31:0]          rsp_data;
    logic                 fifo_full;
    logic                 idle;
    logic                 rsp_error;

    rca_lsq_arbiter #(.NUM_ROWS(NR), .DEPTH(D), .MAX_LOADS(ML), .ROW_W(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
        .req_fn3(req_fn3), .req_load(req_load), .req_store(req_store),
        .lsu_rs1(lsu_rs1), .lsu_rs2(lsu_rs2), .lsu_fn3(lsu_fn3), .lsu_load(lsu_load),
        .lsu_store(lsu_store), .lsu_new_request(lsu_new_request), .lsu_ready(lsu_ready),
        .rca_lsu_lock(rca_lsu_lock), .lsu_load_done(lsu_load_done), .lsu_load_data(lsu_load_data),
        .rsp_valid(rsp_valid), .rsp_row(rsp_row), .rsp_data(rsp_data),
        .fifo_full(fifo_full), .idle(idle), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          row;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic        ld;
        logic        st;
    } ment_t;

    task automatic clr_in();
        req_valid = '0; req_addr = '0; req_data = '0; req_fn3 = '0;
        req_load = '0; req_store = '0; lsu_ready = 1'b0;
        lsu_load_done = 1'b0; lsu_load_data = '0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        nxt(); nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clr_in();
        rst = 1'b1;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_error, fifo_full, idle, rca_lsu_lock, lsu_new_request} !== 6'b000100) begin bad++; $display("FAIL reset_flags got=%b exp=000100", {rsp_valid, rsp_error, fifo_full, idle, rca_lsu_lock, lsu_new_request}); end
        total++; if (rsp_row !== '0) begin bad++; $display("FAIL reset_rsp_row got=%0d exp=0", rsp_row); end
        total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int er[5] = '{0, 1, 2, 3, 0};
        do_reset();
        lsu_ready = 1'b1;
        req_valid = 4'hF; req_load = 4'hF;
        for (int r = 0; r < NR; r++) req_addr[r] = 32'h100 * (r + 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (req_ready !== 4'(1 << er[i])) begin bad++; $display("FAIL rr_order step=%0d got=%b exp=%b", i, req_ready, 4'(1 << er[i])); end
            nxt();
        end
        req_valid = '0;
        // Five returns: tags come back in issue order 0,1,2,3,0.
        for (int i = 0; i < 6; i++) begin
            lsu_load_done = (i < 5);
            lsu_load_data = 32'hA000_0000 + i;
            if (i > 0) begin
                @(negedge clk);
                total++; if ({rsp_valid, rsp_row, rsp_data} !== {1'b1, 2'((i - 1) % 4), 32'hA000_0000 + 32'(i - 1)}) begin bad++; $display("FAIL rr_rsp idx=%0d got=%b/%0d/%h exp=1/%0d/%h", i - 1, rsp_valid, rsp_row, rsp_data, (i - 1) % 4, 32'hA000_0000 + 32'(i - 1)); end
            end
            nxt();
        end
        @(negedge clk);
        total++; if ({idle, rsp_valid} !== 2'b10) begin bad++; $display("FAIL rr_drained got idle=%b rsp_valid=%b exp idle=1 rsp_valid=0", idle, rsp_valid); end
    endtask

    task automatic test_full_fifo();
        logic saw_rsp;
        do_reset();
        req_valid = 4'b0100; req_store = 4'b0100; req_addr[2] = 32'h2000; req_data[2] = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL full_fill step=%0d got=%b exp=0100", i, req_ready); end
            nxt();
        end
        @(negedge clk);
        total++; if ({fifo_full, req_ready} !== 5'b1_0000) begin bad++; $display("FAIL full_flag got full=%b ready=%b exp full=1 ready=0000", fifo_full, req_ready); end
        nxt();
        lsu_ready = 1'b1;
        @(negedge clk);
        total++; if ({lsu_new_request, lsu_store, req_ready} !== 6'b11_0000) begin bad++; $display("FAIL full_pop_refuse got issue=%b st=%b ready=%b exp issue=1 st=1 ready=0000", lsu_new_request, lsu_store, req_ready); end
        nxt();
        lsu_ready = 1'b0;
        @(negedge clk);
        total++; if ({fifo_full, req_ready} !== 5'b0_0100) begin bad++; $display("FAIL full_reopen got full=%b ready=%b exp full=0 ready=0100", fifo_full, req_ready); end
        nxt();
        req_valid = '0; lsu_ready = 1'b1;
        saw_rsp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
            if (idle) break;
            nxt();
        end
        total++; if ({idle, saw_rsp} !== 2'b10) begin bad++; $display("FAIL full_drain got idle=%b store_rsp=%b exp idle=1 store_rsp=0", idle, saw_rsp); end
    endtask

    task automatic test_load_cap();
        int acc = 0;
        int iss = 0;
        do_reset();
        lsu_ready = 1'b1; req_load = 4'hF;
        for (int r = 0; r < NR; r++) req_addr[r] = 32'h3000 + 32'(r);
        for (int c = 0; c < 14; c++) begin
            req_valid = (acc < 6) ? 4'(1 << (acc % 4)) : 4'b0;
            @(negedge clk);
            if (lsu_new_request) iss++;
            if (acc < 6 && req_ready[acc % 4]) acc++;
            nxt();
        end
        total++; if (acc !== 6 || iss !== 4) begin bad++; $display("FAIL cap_issues got acc=%0d iss=%0d exp acc=6 iss=4", acc, iss); end
        lsu_load_done = 1'b1; lsu_load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if ({lsu_new_request, lsu_load, lsu_rs1} !== {2'b01, 32'h3000}) begin bad++; $display("FAIL cap_blocked got issue=%b ld=%b addr=%h exp issue=0 ld=1 addr=00003000", lsu_new_request, lsu_load, lsu_rs1); end
        nxt();
        // Issue of the freed slot and another return in the same cycle.
        lsu_load_data = 32'h1234_5678;
        @(negedge clk);
        total++; if ({lsu_new_request, rsp_valid, rsp_row, rsp_data} !== {2'b11, 2'd0, 32'hDEAD_BEEF}) begin bad++; $display("FAIL cap_release got issue=%b v=%b row=%0d data=%h exp issue=1 v=1 row=0 data=deadbeef", lsu_new_request, rsp_valid, rsp_row, rsp_data); end
        nxt();
        lsu_load_done = 1'b0;
        @(negedge clk);
        total++; if ({lsu_new_request, lsu_rs1, rsp_valid, rsp_row, rsp_data} !== {1'b1, 32'h3001, 1'b1, 2'd1, 32'h1234_5678}) begin bad++; $display("FAIL cap_same_cycle got issue=%b addr=%h v=%b row=%0d data=%h exp issue=1 addr=00003001 v=1 row=1 data=12345678", lsu_new_request, lsu_rs1, rsp_valid, rsp_row, rsp_data); end
        nxt();
        @(negedge clk);
        total++; if ({lsu_new_request, idle, rca_lsu_lock} !== 3'b001) begin bad++; $display("FAIL cap_outstanding got issue=%b idle=%b lock=%b exp 0/0/1", lsu_new_request, idle, rca_lsu_lock); end
    endtask

    task automatic test_spurious();
        do_reset();
        lsu_load_done = 1'b1; lsu_load_data = 32'h5555_AAAA;
        @(negedge clk);
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL spur_idle got=%b exp=1", idle); end
        nxt();
        lsu_load_done = 1'b0;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_error} !== 2'b01) begin bad++; $display("FAIL spur_flag got v=%b err=%b exp v=0 err=1", rsp_valid, rsp_error); end
        nxt(); nxt(); nxt();
        @(negedge clk);
        total++; if (rsp_error !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b exp=1", rsp_error); end
        do_reset();
        @(negedge clk);
        total++; if (rsp_error !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b exp=0", rsp_error); end
        nxt();
    endtask

    task automatic test_async_reset();
        do_reset();
        lsu_ready = 1'b1; req_valid = 4'hF; req_load = 4'hF;
        nxt(); nxt(); nxt();
        #2;
        rst = 1'b1;
        #1;
        total++; if ({idle, rca_lsu_lock, fifo_full, lsu_new_request, rsp_valid} !== 5'b10000) begin bad++; $display("FAIL async_rst got idle=%b lock=%b full=%b issue=%b v=%b exp 1/0/0/0/0", idle, rca_lsu_lock, fifo_full, lsu_new_request, rsp_valid); end
        clr_in();
        nxt();
        rst = 1'b0;
        lsu_load_done = 1'b1;
        nxt();
        lsu_load_done = 1'b0;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_error} !== 2'b01) begin bad++; $display("FAIL async_forget got v=%b err=%b exp v=0 err=1", rsp_valid, rsp_error); end
        nxt();
    endtask

    // Reference model: request queue and tag queue, updated once per cycle.
    task automatic test_random();
        ment_t         mq[$];
        int            mtags[$];
        int            rr = 0;
        logic          m_rv = 1'b0;
        int            m_row = 0;
        logic [31:0]   m_data = '0;
        logic          m_err = 1'b0;
        ment_t         h;
        ment_t         ne;
        int            win;
        logic          full, empty, e_issue, e_idle, ok;
        logic [NR-1:0] e_ready;
        logic [1:0]    ws;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < NR; r++) begin
                req_load[r]  = 1'($urandom % 2);
                req_store[r] = ~req_load[r];
                req_addr[r]  = $urandom;
                req_data[r]  = $urandom;
                req_fn3[r]   = 3'($urandom % 8);
            end
            req_valid     = 4'($urandom % 16);
            lsu_ready     = ($urandom % 4) != 0;
            lsu_load_done = (($urandom % 3) == 0) && (mtags.size() > 0 || ($urandom % 32) == 0);
            lsu_load_data = $urandom;
            @(negedge clk);
            full = (mq.size() == D);
            win = -1;
            for (int k = 0; k < NR; k++) if (win < 0 && req_valid[(rr + k) % NR]) win = (rr + k) % NR;
            e_ready = (win >= 0 && !full) ? 4'(1 << win) : 4'b0;
            empty = (mq.size() == 0);
            h = empty ? '{row: 0, addr: 0, data: 0, fn3: 0, ld: 0, st: 0} : mq[0];
            e_issue = !empty && lsu_ready && (h.st || mtags.size() < ML);
            e_idle = empty && (mtags.size() == 0);
            total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
            total++; if (lsu_new_request !== e_issue) begin bad++; $display("FAIL rnd_issue cyc=%0d got=%b exp=%b", c, lsu_new_request, e_issue); end
            total++; if ({lsu_rs1, lsu_rs2, lsu_fn3, lsu_load, lsu_store} !== {h.addr, h.data, h.fn3, h.ld, h.st}) begin bad++; $display("FAIL rnd_head cyc=%0d got=%h/%h/%0d/%b/%b exp=%h/%h/%0d/%b/%b", c, lsu_rs1, lsu_rs2, lsu_fn3, lsu_load, lsu_store, h.addr, h.data, h.fn3, h.ld, h.st); end
            total++; if ({fifo_full, idle, rca_lsu_lock} !== {full, e_idle, !e_idle}) begin bad++; $display("FAIL rnd_status cyc=%0d got=%b%b%b exp=%b%b%b", c, fifo_full, idle, rca_lsu_lock, full, e_idle, !e_idle); end
            total++; if ({rsp_valid, rsp_error} !== {m_rv, m_err}) begin bad++; $display("FAIL rnd_rsp_flags cyc=%0d got v=%b err=%b exp v=%b err=%b", c, rsp_valid, rsp_error, m_rv, m_err); end
            total++; if ({rsp_row, rsp_data} !== {2'(m_row), m_data}) begin bad++; $display("FAIL rnd_rsp_payload cyc=%0d got row=%0d data=%h exp row=%0d data=%h", c, rsp_row, rsp_data, m_row, m_data); end
            ok = lsu_load_done && (mtags.size() > 0);
            if (ok) begin m_row = mtags.pop_front(); m_data = lsu_load_data; end
            if (lsu_load_done && !ok) m_err = 1'b1;
            m_rv = ok;
            if (e_issue) begin
                if (h.ld) mtags.push_back(h.row);
                mq.delete(0);
            end
            if (e_ready != '0) begin
                ws = 2'(win);
                ne = '{row: win, addr: req_addr[ws], data: req_data[ws], fn3: req_fn3[ws], ld: req_load[ws], st: req_store[ws]};
                mq.push_back(ne);
                rr = (win + 1) % NR;
            end
            nxt();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full_fifo();
        test_load_cap();
        test_spurious();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
